// File: rtl/glitc_clock_pkg.sv
// Shared constants for the GLITC clock block: control-byte bit indices,
// phase-stepper state encoding and the default fine-step period.
package glitc_clock_pkg;

  localparam int unsigned PS_EN_BIT     = 0;
  localparam int unsigned PS_INCDEC_BIT = 1;
  localparam int unsigned PS_DONE_BIT   = 0;
  localparam int unsigned LOCK_SYS_BIT  = 0;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] DONE  = 2'd3;

  localparam int unsigned PERIOD_STEPS_DEF = 672;
  localparam int unsigned POS_W            = 10;

endpackage

// File: rtl/glitc_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
module glitc_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/glitc_phase_shift_controller.sv
// Steps the system MMCM fine phase shift one PSEN/PSDONE handshake at a time,
// tracking absolute position and flagging PSDONE timeouts and lock loss.
module glitc_phase_shift_controller
  import glitc_clock_pkg::*;
#(
  parameter int unsigned PERIOD_STEPS   = PERIOD_STEPS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned STEP_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  input  logic [STEP_W-1:0] cmd_steps_i,
  output logic              cmd_ready_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic [POS_W-1:0]  position_o,
  input  logic [1:0]        mmcm_status_i,
  input  logic [7:0]        phase_ctrl_i,
  output logic [7:0]        phase_ctrl_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic               lock_s;
  logic               ps_done;
  logic [STATE_W-1:0] state_q, state_nx;
  logic               dir_q, dir_nx;
  logic [STEP_W-1:0]  rem_q, rem_nx;
  logic [TO_W-1:0]    tmo_q, tmo_nx;
  logic [POS_W-1:0]   pos_nx;
  logic [1:0]         err_nx;
  logic               done_nx;
  logic               psen_q, psen_nx;
  logic               incdec_q, incdec_nx;
  logic [STEP_W-1:0]  cmd_mag;
  logic               unused_inputs;

  assign unused_inputs = ^{phase_ctrl_i[7:1], mmcm_status_i[1]};

  glitc_sync2 u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (mmcm_status_i[LOCK_SYS_BIT]),
    .q_o     (lock_s)
  );

  // PSDONE shares clk_i with the generator's PSCLK, so no synchroniser.
  assign ps_done     = phase_ctrl_i[PS_DONE_BIT];
  assign cmd_ready_o = (state_q == IDLE) && lock_s;

  // Magnitude as unsigned STEP_W bits: the most negative request maps to 2^(STEP_W-1).
  assign cmd_mag = cmd_steps_i[STEP_W-1] ? (~cmd_steps_i + STEP_W'(1)) : cmd_steps_i;

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos, input logic inc);
    if (inc) step_pos = (pos == POS_W'(PERIOD_STEPS - 1)) ? '0 : pos + POS_W'(1);
    else     step_pos = (pos == '0) ? POS_W'(PERIOD_STEPS - 1) : pos - POS_W'(1);
  endfunction

  always_comb begin
    state_nx  = state_q;
    dir_nx    = dir_q;
    rem_nx    = rem_q;
    tmo_nx    = tmo_q;
    pos_nx    = position_o;
    err_nx    = err_o;
    done_nx   = 1'b0;
    psen_nx   = 1'b0;
    incdec_nx = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          dir_nx = ~cmd_steps_i[STEP_W-1];
          rem_nx = cmd_mag;
          err_nx = 2'b00;
          if (cmd_mag == '0) done_nx  = 1'b1;
          else               state_nx = ISSUE;
        end
      end
      ISSUE: begin
        tmo_nx   = TO_W'(TIMEOUT_CYCLES - 1);
        state_nx = WAIT;
      end
      WAIT: begin
        if (ps_done) begin
          pos_nx   = step_pos(position_o, dir_q);
          rem_nx   = rem_q - STEP_W'(1);
          state_nx = (rem_q == STEP_W'(1)) ? DONE : ISSUE;
        end else if (tmo_q == '0) begin
          err_nx[0] = 1'b1;
          state_nx  = DONE;
        end else begin
          tmo_nx = tmo_q - TO_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Lock loss overrides everything: the MMCM reset zeroes its phase offset.
    if (!lock_s) begin
      pos_nx = '0;
      if (state_q == ISSUE || state_q == WAIT) begin
        err_nx[1] = 1'b1;
        state_nx  = DONE;
      end
    end

    if (state_nx == DONE) done_nx = 1'b1;
    psen_nx   = (state_nx == ISSUE);
    incdec_nx = (state_nx == ISSUE || state_nx == WAIT) && dir_nx;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      rem_q      <= '0;
      tmo_q      <= '0;
      position_o <= '0;
      err_o      <= 2'b00;
      done_o     <= 1'b0;
      psen_q     <= 1'b0;
      incdec_q   <= 1'b0;
    end else begin
      state_q    <= state_nx;
      dir_q      <= dir_nx;
      rem_q      <= rem_nx;
      tmo_q      <= tmo_nx;
      position_o <= pos_nx;
      err_o      <= err_nx;
      done_o     <= done_nx;
      psen_q     <= psen_nx;
      incdec_q   <= incdec_nx;
    end
  end

  always_comb begin
    phase_ctrl_o                = 8'h00;
    phase_ctrl_o[PS_EN_BIT]     = psen_q;
    phase_ctrl_o[PS_INCDEC_BIT] = incdec_q;
  end

endmodule
